// File: rtl/signal_capture_pkg.sv
// Shared scope-acquisition definitions: frame geometry, sample width and capture FSM states.
package signal_capture_pkg;

    localparam int unsigned CAPTURE_DEPTH     = 512;
    localparam int unsigned SAMPLE_W          = 12;
    localparam int unsigned AUTO_TIMEOUT_DFLT = 1000000;
    localparam int unsigned DECIM_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TRIG,
        CAPTURE,
        WAIT_VBLANK
    } capture_state_t;

endpackage

// File: rtl/signal_capture_trigger_detect.sv
// Level/edge trigger: remembers the previous kept sample and flags a threshold crossing.
module signal_capture_trigger_detect
    import signal_capture_pkg::*;
#(
    parameter int unsigned DATA_W = SAMPLE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              armed,
    input  logic              kept,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] level,
    input  logic              falling,
    output logic              hit_c
);

    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_ok_q, prev_ok_d;
    logic              rise_c, fall_c;

    // clear wins so the first kept sample after arming only seeds prev
    always_comb begin
        prev_d    = prev_q;
        prev_ok_d = prev_ok_q;
        if (kept) begin
            prev_d    = sample;
            prev_ok_d = 1'b1;
        end
        if (clear) begin
            prev_ok_d = 1'b0;
        end
    end

    assign rise_c = (prev_q < level) && (sample >= level);
    assign fall_c = (prev_q > level) && (sample <= level);
    assign hit_c  = armed && kept && prev_ok_q && (falling ? fall_c : rise_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
        end
    end

endmodule

// File: rtl/signal_capture.sv
// Scope acquisition: decimate, trigger, fill a shadow frame and publish it tear-free on vblank.
module signal_capture
    import signal_capture_pkg::*;
#(
    parameter int unsigned DEPTH        = CAPTURE_DEPTH,
    parameter int unsigned DATA_W       = SAMPLE_W,
    parameter int unsigned AUTO_TIMEOUT = AUTO_TIMEOUT_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  sample,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  trig_level,
    input  logic               trig_falling,
    input  logic [DECIM_W-1:0] decim,
    input  logic               run,
    input  logic               vblnk,
    output logic [DATA_W-1:0]  data_display [0:DEPTH-1],
    output logic               frame_ready,
    output logic               triggered
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

    capture_state_t     state_q, state_d;
    logic [DECIM_W-1:0] dcnt_q, dcnt_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pend_q, pend_d;
    logic               trig_q, trig_d;
    logic               pub_q, pub_d;
    logic               ready_q, ready_d;
    logic               vblnk_prev_q, vblnk_prev_d;
    logic [DATA_W-1:0]  shadow_q [0:DEPTH-1];
    logic [DATA_W-1:0]  shadow_d [0:DEPTH-1];
    logic [DATA_W-1:0]  disp_q   [0:DEPTH-1];
    logic [DATA_W-1:0]  disp_d   [0:DEPTH-1];

    logic               kept_c, hit_c, armed_c, enter_wait_c, vrise_c;
    logic               wr_en_c, publish_c;
    logic [IDX_W-1:0]   wr_idx_c;

    assign kept_c       = sample_valid && (dcnt_q == decim);
    assign armed_c      = (state_q == WAIT_TRIG);
    assign enter_wait_c = (state_d == WAIT_TRIG) && (state_q != WAIT_TRIG);
    assign vrise_c      = vblnk && !vblnk_prev_q;

    signal_capture_trigger_detect #(
        .DATA_W (DATA_W)
    ) u_trig (
        .clk     (clk),
        .rst     (rst),
        .clear   (enter_wait_c),
        .armed   (armed_c),
        .kept    (kept_c),
        .sample  (sample),
        .level   (trig_level),
        .falling (trig_falling),
        .hit_c   (hit_c)
    );

    // decimation counter free-runs across states, restarts when arming
    always_comb begin
        dcnt_d = dcnt_q;
        if (sample_valid) begin
            dcnt_d = kept_c ? '0 : dcnt_q + DECIM_W'(1);
        end
        if (enter_wait_c) begin
            dcnt_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        to_d      = '0;
        idx_d     = idx_q;
        pend_d    = pend_q;
        wr_en_c   = 1'b0;
        wr_idx_c  = idx_q;
        publish_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                to_d = to_q + TO_W'(1);
                if (!run) begin
                    state_d = IDLE;
                end else if (hit_c) begin
                    wr_en_c  = 1'b1;
                    wr_idx_c = '0;
                    idx_d    = IDX_W'(1);
                    pend_d   = 1'b1;
                    state_d  = CAPTURE;
                end else if (to_q == TO_W'(AUTO_TIMEOUT - 1)) begin
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (kept_c) begin
                    wr_en_c = 1'b1;
                    if (idx_q == IDX_W'(DEPTH - 1)) begin
                        state_d = WAIT_VBLANK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            WAIT_VBLANK: begin
                if (vrise_c) begin
                    publish_c = 1'b1;
                    state_d   = run ? WAIT_TRIG : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_c) begin
            shadow_d[wr_idx_c] = sample;
        end
        disp_d = disp_q;
        if (publish_c) begin
            disp_d = shadow_q;
        end
    end

    assign vblnk_prev_d = vblnk;
    assign pub_d        = publish_c;
    assign ready_d      = pub_q;
    assign trig_d       = publish_c ? pend_q : trig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dcnt_q       <= '0;
            to_q         <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            trig_q       <= 1'b0;
            pub_q        <= 1'b0;
            ready_q      <= 1'b0;
            vblnk_prev_q <= 1'b0;
            shadow_q     <= '{default: '0};
            disp_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            to_q         <= to_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            trig_q       <= trig_d;
            pub_q        <= pub_d;
            ready_q      <= ready_d;
            vblnk_prev_q <= vblnk_prev_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
        end
    end

    assign data_display = disp_q;
    assign frame_ready  = ready_q;
    assign triggered    = trig_q;

endmodule

// File: tb/tb_signal_capture.sv
// Bench for signal_capture: directed scope scenarios plus random traffic against a queue-based frame model.
module tb_signal_capture;

    localparam int unsigned DEPTH   = 512;
    localparam int unsigned DW      = 12;
    localparam int          AUTO_TO = 64;

    localparam int M_OFF  = 0;
    localparam int M_ARM  = 1;
    localparam int M_FILL = 2;
    localparam int M_HOLD = 3;

    logic          clk;
    logic          rst;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic [DW-1:0] trig_level;
    logic          trig_falling;
    logic [3:0]    decim;
    logic          run;
    logic          vblnk;
    logic [DW-1:0] data_display [0:DEPTH-1];
    logic          frame_ready;
    logic          triggered;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit in_rand = 1'b0;
    int n_fr_rand = 0;
    int ramp = 0;
    int step = 1;
    bit use_ramp = 1'b0;

    // reference model state
    int m_mode, m_dc, m_wait, m_prev;
    bit m_have_prev, m_vb, m_pend_pub, m_frame_trig;
    int m_frame[$];
    int exp_disp[DEPTH];
    bit exp_ready, exp_trig;

    signal_capture #(
        .DEPTH        (DEPTH),
        .DATA_W       (DW),
        .AUTO_TIMEOUT (AUTO_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .decim        (decim),
        .run          (run),
        .vblnk        (vblnk),
        .data_display (data_display),
        .frame_ready  (frame_ready),
        .triggered    (triggered)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // one frame = DEPTH kept samples after a crossing or after AUTO_TO armed cycles
    task automatic model_step();
        bit kept, hit, vrise, arm;
        int s, lv;
        if (rst) begin
            m_mode = M_OFF; m_dc = 0; m_wait = 0; m_prev = 0;
            m_have_prev = 1'b0; m_vb = 1'b0; m_pend_pub = 1'b0; m_frame_trig = 1'b0;
            m_frame.delete();
            exp_ready = 1'b0; exp_trig = 1'b0;
            foreach (exp_disp[i]) exp_disp[i] = 0;
            return;
        end
        s     = int'(sample);
        lv    = int'(trig_level);
        kept  = sample_valid && (m_dc == int'(decim));
        vrise = vblnk && !m_vb;
        hit   = kept && m_have_prev &&
                (trig_falling ? (m_prev > lv && s <= lv) : (m_prev < lv && s >= lv));
        exp_ready  = m_pend_pub;
        m_pend_pub = 1'b0;
        arm = 1'b0;
        case (m_mode)
            M_OFF: if (run) arm = 1'b1;
            M_ARM: begin
                if (!run) m_mode = M_OFF;
                else if (hit) begin
                    m_frame.delete(); m_frame.push_back(s); m_frame_trig = 1'b1; m_mode = M_FILL;
                end else if (m_wait == AUTO_TO - 1) begin
                    m_frame.delete(); m_frame_trig = 1'b0; m_mode = M_FILL;
                end else m_wait++;
            end
            M_FILL: if (kept) begin
                m_frame.push_back(s);
                if (m_frame.size() == DEPTH) m_mode = M_HOLD;
            end
            default: if (vrise) begin
                foreach (exp_disp[i]) exp_disp[i] = m_frame[i];
                exp_trig   = m_frame_trig;
                m_pend_pub = 1'b1;
                if (run) arm = 1'b1;
                else m_mode = M_OFF;
            end
        endcase
        if (sample_valid) m_dc = kept ? 0 : (m_dc + 1) % 16;
        if (kept) begin
            m_prev = s;
            m_have_prev = 1'b1;
        end
        if (arm) begin
            m_mode = M_ARM; m_dc = 0; m_have_prev = 1'b0; m_wait = 0;
        end
        m_vb = vblnk;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin : compare
        int bad;
        if (chk_en) begin
            bad = -1;
            for (int i = 0; i < DEPTH; i++)
                if (bad < 0 && int'(data_display[i]) != exp_disp[i]) bad = i;
            if (bad < 0) bad = 0;
            check($sformatf("data_display[%0d]", bad), int'(data_display[bad]), exp_disp[bad]);
            check("frame_ready", int'(frame_ready), int'(exp_ready));
            check("triggered", int'(triggered), int'(exp_trig));
            if (in_rand && frame_ready) n_fr_rand++;
        end
    end

    task automatic cyc();
        @(negedge clk);
        if (use_ramp) begin
            sample = 12'(ramp);
            ramp   = (ramp + step) & 4095;
        end
    endtask

    // raise vblnk; expect display update after 1 cycle and frame_ready after 2
    task automatic pub_check(input string tag, input bit expect_pub, input int d0, input int trg);
        int seen;
        seen = -1;
        cyc();
        vblnk = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 1) check({tag, "_d0"}, int'(data_display[0]), d0);
            if (frame_ready && seen < 0) seen = k;
        end
        vblnk = 1'b0;
        check({tag, "_fr_cycle"}, seen, expect_pub ? 2 : -1);
        check({tag, "_triggered"}, int'(triggered), trg);
    endtask

    initial begin
        int fr_cnt, nz, w;
        rst = 1'b1; sample = '0; sample_valid = 1'b0; trig_level = '0;
        trig_falling = 1'b0; decim = '0; run = 1'b0; vblnk = 1'b0;
        repeat (3) cyc();
        chk_en = 1'b1;
        check("rst_frame_ready", int'(frame_ready), 0);
        check("rst_triggered", int'(triggered), 0);
        check("rst_d0", int'(data_display[0]), 0);
        rst = 1'b0;
        sample_valid = 1'b1;

        // rising edge, decim 0
        trig_level = 12'd2048; trig_falling = 1'b0; decim = 4'd0;
        ramp = 2000; step = 1; use_ramp = 1'b1;
        cyc(); run = 1'b1;
        repeat (600) cyc();
        run = 1'b0;
        pub_check("rise", 1'b1, 2048, 1);
        check("rise_d511", int'(data_display[511]), 2559);
        check("model_rise_d0", exp_disp[0], 2048);
        check("model_rise_d511", exp_disp[511], 2559);

        // falling edge
        trig_level = 12'd1000; trig_falling = 1'b1;
        ramp = 1040; step = -1;
        cyc(); run = 1'b1;
        repeat (600) cyc();
        run = 1'b0;
        pub_check("fall", 1'b1, 1000, 1);
        check("fall_d1", int'(data_display[1]), 999);
        check("fall_d511", int'(data_display[511]), 489);
        check("model_fall_d1", exp_disp[1], 999);

        // decimation by 4
        trig_level = 12'd2048; trig_falling = 1'b0; decim = 4'd3;
        ramp = 2010; step = 1;
        cyc(); run = 1'b1;
        repeat (2200) cyc();
        run = 1'b0;
        pub_check("decim", 1'b1, 2050, 1);
        check("decim_d1", int'(data_display[1]), 2054);
        check("decim_d511", int'(data_display[511]), 4094);
        check("model_decim_d0", exp_disp[0], 2050);

        // auto trigger: capture begins 64 cycles after arming
        decim = 4'd0; trig_level = 12'd4095;
        ramp = 0; step = 1;
        cyc(); run = 1'b1;
        repeat (600) cyc();
        run = 1'b0;
        pub_check("auto_ramp", 1'b1, 65, 0);
        check("auto_ramp_d511", int'(data_display[511]), 576);
        check("model_auto_d0", exp_disp[0], 65);

        // constant input, capture ends with vblnk already high, then freeze
        use_ramp = 1'b0; sample = 12'd100; trig_level = 12'd2048;
        cyc(); run = 1'b1; vblnk = 1'b1;
        fr_cnt = 0;
        for (int k = 0; k < 620; k++) begin
            cyc();
            if (frame_ready) fr_cnt++;
        end
        run = 1'b0;
        repeat (5) begin
            cyc();
            if (frame_ready) fr_cnt++;
        end
        check("hold_no_publish", fr_cnt, 0);
        check("hold_d0_unchanged", int'(data_display[0]), 65);
        vblnk = 1'b0;
        repeat (3) cyc();
        pub_check("auto_const", 1'b1, 100, 0);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (int'(data_display[i]) != 100) nz++;
        check("auto_const_entries_not_100", nz, 0);
        for (int r = 0; r < 3; r++) pub_check("frozen", 1'b0, 100, 0);

        // reset in the middle of a capture
        sample_valid = 1'b1; trig_level = 12'd2048; trig_falling = 1'b0;
        ramp = 2000; step = 1; use_ramp = 1'b1;
        cyc(); run = 1'b1;
        repeat (248) cyc();
        rst = 1'b1;
        ramp = 2000;
        cyc();
        rst = 1'b0;
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (data_display[i] != '0) nz++;
        check("midrst_nonzero_entries", nz, 0);
        check("midrst_frame_ready", int'(frame_ready), 0);
        check("midrst_triggered", int'(triggered), 0);
        repeat (600) cyc();
        run = 1'b0;
        pub_check("after_rst", 1'b1, 2048, 1);
        check("after_rst_d511", int'(data_display[511]), 2559);

        // randomized traffic
        use_ramp = 1'b0; run = 1'b1; in_rand = 1'b1;
        for (int c = 0; c < 25000; c++) begin
            cyc();
            if ((c % 4000) < 2000) sample = 12'($urandom_range(0, 4095));
            else begin
                w = int'(sample) + int'($urandom_range(0, 200)) - 100;
                if (w < 0) w = 0;
                if (w > 4095) w = 4095;
                sample = 12'(w);
            end
            sample_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) decim = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                trig_level   = 12'($urandom_range(500, 3500));
                trig_falling = ($urandom_range(0, 1) == 1);
            end
            vblnk = ((c % 300) < 20);
            if ($urandom_range(0, 999) == 0) run = !run;
            rst = ($urandom_range(0, 9999) == 0);
        end
        rst = 1'b0;
        cyc();
        in_rand = 1'b0;
        check("rand_publishes_seen", int'(n_fr_rand >= 3), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/signal_capture.md
Name: signal_capture

Overview:
- Acquisition stage directly upstream of the oscilloscope display renderer.
- Takes a stream of 12-bit ADC samples and applies decimation and level/edge triggering.
- Captures 512 post-trigger samples into a shadow buffer.
- Publishes the shadow buffer to the renderer's sample array only at the start of vertical blanking, so the drawn trace never tears mid-frame.

Parameters:
- DEPTH, 512, number of samples per captured frame (renderer array size).
- DATA_W, 12, sample width in bits.
- AUTO_TIMEOUT, 1000000, clk cycles spent in WAIT_TRIG before a forced (untriggered) capture.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample  in  DATA_W  ADC sample, unsigned.
- sample_valid  in  1  qualifies sample for one cycle.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
- decim  in  4  keep one valid sample in every decim+1.
- run  in  1  1 = continuous acquisition, 0 = freeze after the current frame.
- vblnk  in  1  vertical blank from the VGA timing chain.
- data_display  out  DATA_W x [0:DEPTH-1]  published frame; index 0 is the trigger sample.
- frame_ready  out  1  one-cycle pulse after each publish.
- triggered  out  1  1 = last published frame came from a real trigger, 0 = from auto timeout.

Behaviour:
- Reset:
  - state = IDLE.
  - All data_display entries, shadow buffer, frame_ready, triggered, decimation counter, write index, timeout counter, prev sample and prev_ok cleared to 0.
  - vblnk_d cleared to 0.
- Decimation:
  - A 4-bit counter advances on every sample_valid.
  - A "kept" sample occurs when sample_valid=1 and counter==decim; the counter then returns to 0.
  - The counter is free-running across states; rst or entry to WAIT_TRIG clears it.
  - decim=0 keeps every valid sample.
- Trigger test (kept samples only, WAIT_TRIG only, requires prev_ok=1):
  - Rising: prev < trig_level AND sample >= trig_level.
  - Falling: prev > trig_level AND sample <= trig_level.
  - prev is updated on every kept sample; prev_ok is set by the first kept sample after entry to WAIT_TRIG.
- States:
  - IDLE: run=1 -> WAIT_TRIG. Otherwise data_display holds its value.
  - WAIT_TRIG:
    - Timeout counter increments every clk.
    - On a trigger hit, the sample is written to shadow[0], write index = 1, triggered_pending = 1, -> CAPTURE.
    - When the counter reaches AUTO_TIMEOUT-1 with no hit, -> CAPTURE with index 0 and triggered_pending = 0.
    - If both occur in the same cycle, the trigger wins.
  - CAPTURE:
    - Each kept sample is written to shadow[index] and index increments.
    - The write at index DEPTH-1 -> WAIT_VBLANK.
    - Index never wraps.
  - WAIT_VBLANK:
    - On the vblnk rising edge (vblnk=1, vblnk_d=0), the whole shadow buffer is copied to data_display in that cycle.
    - triggered <= triggered_pending.
    - frame_ready pulses on the next cycle.
    - Then run=1 -> WAIT_TRIG, run=0 -> IDLE.
    - If vblnk is already high on entry, wait for the next rising edge.
- run deasserted during WAIT_TRIG -> IDLE immediately, no publish. During CAPTURE or WAIT_VBLANK the frame completes and publishes, then -> IDLE.
- trig_level, trig_falling and decim are sampled live; changes mid-capture affect only subsequent kept samples.
- Synchronous reset mid-operation aborts immediately and clears all outputs, including data_display.
- Latency: the trigger sample appears in data_display at most one frame after capture completes. Timing runs from the vblnk rising edge: data_display is updated 1 cycle after it, and frame_ready is high 2 cycles after it.

Decomposition:
- Shared vga/scope package holds:
  - CAPTURE_DEPTH=512, SAMPLE_W=12, AUTO_TIMEOUT default.
  - capture_state_t enum {IDLE, WAIT_TRIG, CAPTURE, WAIT_VBLANK}.
- One sub-module, trigger_detect:
  - Owns the prev register, prev_ok and the edge/level comparison.
  - Outputs a single-cycle hit.

Test Plan:
- Rising trigger:
  - Stimulus: decim=0, trig_level=2048, ramp 0..4095 step 1 every cycle, run=1.
  - Required: data_display[0]=2048, [511]=2559, triggered=1, frame_ready pulse 2 cycles after the vblnk rise.
- Falling trigger:
  - Stimulus: trig_falling=1, descending ramp 4095..0, level 1000.
  - Required: [0]=1000, [1]=999.
- Decimation:
  - Stimulus: decim=3 with the ramp.
  - Required: consecutive entries differ by 4, [0] is the first kept sample >=2048 following a kept sample below it.
- Auto trigger:
  - Stimulus: constant sample 100, level 2048, AUTO_TIMEOUT=64.
  - Required: capture starts 64 cycles after WAIT_TRIG entry, all entries =100, triggered=0.
- Tear-free publish and freeze:
  - Stimulus: capture completes with vblnk high, then run drops.
  - Required: data_display is unchanged until the next vblnk rise; one publish occurs, then IDLE; no further frame_ready.
- Reset mid-CAPTURE:
  - Stimulus: rst for 1 cycle at index 200.
  - Required: all data_display entries 0, frame_ready 0, and the next frame restarts from WAIT_TRIG after run=1.
